bp_stream_host_mmio_target: RTL

- Host-side endpoint that sits directly downstream of the BedRock-to-stream MMIO bridge.
- Consumes its 32-bit outbound stream, where each command is two words: address first, then data.
- Decodes a fixed host address map: putchar, getchar, finish and cycle-counter read.
- For read addresses, produces the two 32-bit response words, low word first, that the bridge's serial-in/parallel-out assembles into a 64-bit read response.
- The stream carries no message type, so read vs. write is determined purely by address.

---
 rtl/bp_stream_host_pkg.sv | 20 ++
 rtl/bsg_counter_clear_up.sv | 44 ++++
 rtl/bp_stream_host_mmio_target.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bp_stream_host_pkg.sv
// Shared definitions for the host MMIO stream target.
// Holds the default host address map, the FSM state encoding and the
// all-ones value returned by getchar when no RX byte is available.
package bp_stream_host_pkg;

  localparam logic [31:0] getchar_addr_gp = 32'h0010_0000;
  localparam logic [31:0] putchar_addr_gp = 32'h0010_1000;
  localparam logic [31:0] finish_addr_gp  = 32'h0010_2000;
  localparam logic [31:0] cycle_addr_gp   = 32'h0010_3000;

  localparam logic [63:0] eof_val_gp = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    e_addr    = 2'd0,
    e_data    = 2'd1,
    e_resp_lo = 2'd2,
    e_resp_hi = 2'd3
  } state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Free-running up counter with synchronous clear.
// Ports:
//   clk_i   - clock
//   reset_i - synchronous active-high reset, loads init_val_p
//   clear_i - synchronous clear, loads init_val_p
//   up_i    - increment by one this cycle
//   count_o - current count; wraps from all-ones to zero
module bsg_counter_clear_up #(
  parameter int unsigned       width_p    = 64,
  parameter logic [width_p-1:0] init_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  // Next count: clear wins over increment; natural wrap at the top.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = init_val_p;
    end else if (up_i) begin
      count_d = count_q + {{(width_p-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= init_val_p;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_stream_host_mmio_target.sv
// Host-side endpoint for the BedRock-to-stream MMIO bridge.
// Each inbound command is two stream words (address, then data). The address
// alone selects the operation: putchar/finish are writes, getchar/cycle are
// reads that return a 64-bit value as two stream words, low word first.
// Ports:
//   clk_i, reset_i                          - clock, synchronous active-high reset
//   stream_v_i/stream_data_i/stream_ready_o - inbound command words
//   stream_v_o/stream_data_o/stream_yumi_i  - outbound response words
//   tx_v_o/tx_data_o/tx_ready_i             - UART TX byte
//   rx_v_i/rx_data_i/rx_yumi_o              - UART RX byte
//   finish_o/finish_code_o                  - sticky finish flag and code
//   error_o                                 - sticky unknown-address flag
module bp_stream_host_mmio_target
  import bp_stream_host_pkg::*;
#(
  parameter int unsigned stream_data_width_p = 32,
  parameter logic [31:0] getchar_addr_p      = getchar_addr_gp,
  parameter logic [31:0] putchar_addr_p      = putchar_addr_gp,
  parameter logic [31:0] finish_addr_p       = finish_addr_gp,
  parameter logic [31:0] cycle_addr_p        = cycle_addr_gp
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic                           stream_ready_o,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_yumi_i,
  output logic                           tx_v_o,
  output logic [7:0]                     tx_data_o,
  input  logic                           tx_ready_i,
  input  logic                           rx_v_i,
  input  logic [7:0]                     rx_data_i,
  output logic                           rx_yumi_o,
  output logic                           finish_o,
  output logic [7:0]                     finish_code_o,
  output logic                           error_o
);

  state_e                               state_q, state_d;
  logic [stream_data_width_p-1:0]       addr_q, addr_d;
  logic [2*stream_data_width_p-1:0]     resp_q, resp_d;
  logic                                 finish_q, finish_d;
  logic [7:0]                           finish_code_q, finish_code_d;
  logic                                 error_q, error_d;
  logic [63:0]                          cycle_cnt;

  logic is_get, is_put, is_fin, is_cyc;

  bsg_counter_clear_up #(
    .width_p    (64),
    .init_val_p (64'h0)
  ) cycle_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (1'b0),
    .up_i    (1'b1),
    .count_o (cycle_cnt)
  );

  // Full 32-bit address match; no masking so aliases are reported as errors.
  assign is_get = (addr_q == getchar_addr_p);
  assign is_put = (addr_q == putchar_addr_p);
  assign is_fin = (addr_q == finish_addr_p);
  assign is_cyc = (addr_q == cycle_addr_p);

  // Next-state, decode and handshake outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    resp_d         = resp_q;
    finish_d       = finish_q;
    finish_code_d  = finish_code_q;
    error_d        = error_q;
    stream_ready_o = 1'b0;
    stream_v_o     = 1'b0;
    stream_data_o  = '0;
    tx_v_o         = 1'b0;
    tx_data_o      = 8'h00;
    rx_yumi_o      = 1'b0;

    case (state_q)
      e_addr: begin
        stream_ready_o = 1'b1;
        if (stream_v_i) begin
          addr_d  = stream_data_i;
          state_d = e_data;
        end else begin
          state_d = e_addr;
        end
      end

      e_data: begin
        // putchar forwards the stream handshake straight to TX so the data
        // word and the TX byte are consumed in the same cycle.
        if (is_put) begin
          stream_ready_o = tx_ready_i;
          tx_v_o         = stream_v_i;
          tx_data_o      = stream_data_i[7:0];
        end else begin
          stream_ready_o = 1'b1;
        end

        if (stream_v_i && (!is_put || tx_ready_i)) begin
          if (is_put) begin
            state_d = e_addr;
          end else if (is_fin) begin
            finish_d      = 1'b1;
            finish_code_d = stream_data_i[7:0];
            state_d       = e_addr;
          end else if (is_get) begin
            rx_yumi_o = rx_v_i;
            if (rx_v_i) begin
              resp_d = {56'h0, rx_data_i};
            end else begin
              resp_d = eof_val_gp;
            end
            state_d = e_resp_lo;
          end else if (is_cyc) begin
            resp_d  = cycle_cnt;
            state_d = e_resp_lo;
          end else begin
            // No response for an unknown address: the bridge stalls and
            // error_o is the only indication.
            error_d = 1'b1;
            state_d = e_addr;
          end
        end else begin
          state_d = e_data;
        end
      end

      e_resp_lo: begin
        stream_v_o    = 1'b1;
        stream_data_o = resp_q[stream_data_width_p-1:0];
        if (stream_yumi_i) begin
          state_d = e_resp_hi;
        end else begin
          state_d = e_resp_lo;
        end
      end

      e_resp_hi: begin
        stream_v_o    = 1'b1;
        stream_data_o = resp_q[2*stream_data_width_p-1:stream_data_width_p];
        if (stream_yumi_i) begin
          state_d = e_addr;
        end else begin
          state_d = e_resp_hi;
        end
      end

      default: begin
        state_d = e_addr;
      end
    endcase
  end

  // State, command and status registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_addr;
      addr_q        <= '0;
      resp_q        <= '0;
      finish_q      <= 1'b0;
      finish_code_q <= 8'h00;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      resp_q        <= resp_d;
      finish_q      <= finish_d;
      finish_code_q <= finish_code_d;
      error_q       <= error_d;
    end
  end

  assign finish_o      = finish_q;
  assign finish_code_o = finish_code_q;
  assign error_o       = error_q;

endmodule
